// File: rtl/code2421_seg_scan.sv
// code2421_seg_scan: captures a history of distinct 2421 codes from the upstream
// counter and time-multiplexes the history onto a common-anode 7-segment display.
// Optional feature macro: BLANK_UNUSED_EN (blank history slots not yet written since reset).
module code2421_seg_scan #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        code_in,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic              err,
    output logic [3:0]        wrap_cnt
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [3:0]       hist [DIGITS];
    logic [3:0]       prev_code;
    logic [IDX_W-1:0] idx;
    logic [DIV_W-1:0] divider;

    logic             legal_c;
    logic             push_c;
    logic             wrap_c;
    logic [6:0]       seg_next_c;

    // 2421 legality: the six codes 0101..1010 never appear on a valid counter
    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010: return 1'b0;
            default:                   return 1'b1;
        endcase
    endfunction

    // 2421 code to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'b0000: return 7'h40;
            4'b0001: return 7'h79;
            4'b0010: return 7'h24;
            4'b0011: return 7'h30;
            4'b0100: return 7'h19;
            4'b1011: return 7'h12;
            4'b1100: return 7'h02;
            4'b1101: return 7'h78;
            4'b1110: return 7'h00;
            4'b1111: return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Input qualification: push on a new legal code, wrap on 9 -> 0
    always_comb begin
        legal_c = is_legal(code_in);
        push_c  = legal_c && (code_in != prev_code);
        wrap_c  = (prev_code == 4'b1111) && (code_in == 4'b0000);
    end

`ifdef BLANK_UNUSED_EN
    localparam int unsigned FILL_W = $clog2(DIGITS + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DIGITS);

    logic [FILL_W-1:0] fill;

    // Number of slots written since reset, saturating at DIGITS
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill <= '0;
        end else if (push_c && (fill != FILL_MAX)) begin
            fill <= fill + FILL_W'(1);
        end
    end

    // Segment pattern for the slot being scanned; unwritten slots stay dark
    always_comb begin
        seg_next_c = seg_of(hist[idx]);
        if (FILL_W'(idx) >= fill) begin
            seg_next_c = SEG_BLANK;
        end
    end
`else
    // Segment pattern for the slot being scanned
    always_comb begin
        seg_next_c = seg_of(hist[idx]);
    end
`endif

    // History shift register: newest value in slot 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                hist[k] <= 4'b0000;
            end
        end else if (push_c) begin
            for (int unsigned k = DIGITS - 1; k > 0; k--) begin
                hist[k] <= hist[k-1];
            end
            hist[0] <= code_in;
        end
    end

    // Previous-sample register, sticky error flag and wrap counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_code <= 4'b0000;
            err       <= 1'b0;
            wrap_cnt  <= 4'd0;
        end else begin
            prev_code <= code_in;
            if (!legal_c) begin
                err <= 1'b1;
            end
            if (wrap_c) begin
                wrap_cnt <= wrap_cnt + 4'd1;
            end
        end
    end

    // Scan timing: each digit is held for SCAN_DIV cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divider <= '0;
            idx     <= '0;
        end else if (divider == DIV_LAST) begin
            divider <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // Display outputs registered together so an/seg/dp stay aligned
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_next_c;
            dp  <= (idx != '0);
        end
    end

endmodule

// File: tb/tb_code2421_seg_scan.sv
// Bench for code2421_seg_scan (DIGITS=4, SCAN_DIV=4); honours BLANK_UNUSED_EN.
module tb_code2421_seg_scan;

    localparam int unsigned DIGITS = 4;
`ifdef BLANK_UNUSED_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] code_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       err;
    logic [3:0] wrap_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       err;
        logic [3:0] wrap;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [3:0] m_hist [DIGITS];
    logic [3:0] m_prev;
    int         m_idx, m_div, m_fill, m_wrap;
    logic       m_err;
    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    code2421_seg_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clock(clock), .reset(reset), .code_in(code_in), .seg(seg),
        .an(an), .dp(dp), .err(err), .wrap_cnt(wrap_cnt)
    );

    always #5 clock = ~clock;

    function automatic int digit_of(input logic [3:0] c);
        return 2 * int'(c[3]) + 4 * int'(c[2]) + 2 * int'(c[1]) + int'(c[0]);
    endfunction

    function automatic bit legal_of(input logic [3:0] c);
        return (digit_of(c) < 5) ? (c[3] == 1'b0) : (c[3] == 1'b1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DIGITS; k++) m_hist[k] = 4'b0000;
        m_prev = 4'b0000; m_idx = 0; m_div = 0; m_fill = 0; m_wrap = 0; m_err = 1'b0;
        sb_q.delete();
    endtask

    // Drive one code for one clock, predict the post-edge outputs into the scoreboard
    task automatic drive_cycle(input logic [3:0] c);
        exp_t e;
        code_in = c;
        e.an  = ~(4'b0001 << m_idx);
        e.seg = (BLANK && (m_idx >= m_fill)) ? 7'h7F : segtab[digit_of(m_hist[m_idx])];
        e.dp  = (m_idx != 0);
        if (!legal_of(c)) m_err = 1'b1;
        if (m_prev == 4'b1111 && c == 4'b0000) m_wrap = (m_wrap + 1) % 16;
        if (legal_of(c) && c != m_prev) begin
            for (int k = DIGITS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = c;
            if (m_fill < DIGITS) m_fill++;
        end
        m_prev = c;
        if (m_div == 3) begin m_div = 0; m_idx = (m_idx + 1) % DIGITS; end
        else m_div++;
        e.err  = m_err;
        e.wrap = 4'(m_wrap);
        sb_q.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0; code_in = 4'b0000;
        model_reset();
        #22;
        release_reset();
        for (int n = 0; n < 6; n++) begin
            drive_cycle(4'(n));
            e = sb_q.pop_front(); tests++;
            if ({an, seg, dp, err, wrap_cnt} !== e) begin
                fails++;
                $display("FAIL reset_pre: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                         an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
            end
        end
        #1 reset = 1'b0;
        #1; tests++;
        if ({an, seg, dp, err, wrap_cnt} !== {4'hF, 7'h7F, 1'b1, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL reset_async: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=1111 seg=7f dp=1 err=0 wrap=0",
                     an, seg, dp, err, wrap_cnt);
        end
        @(posedge clock); #1; tests++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_hold: got an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", an, seg, dp);
        end
        release_reset();
    endtask

    task automatic test_history();
        exp_t e;
        logic [6:0] want [DIGITS];
        want = '{7'h30, 7'h24, 7'h79, BLANK ? 7'h7F : 7'h40};
        for (int n = 0; n < 24; n++) begin
            drive_cycle((n < 8) ? 4'(n / 2) : 4'b0011);
            e = sb_q.pop_front(); tests++;
            if ({an, seg, dp, err, wrap_cnt} !== e) begin
                fails++;
                $display("FAIL sb_history: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                         an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
            end
            if (n >= 8) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (an == ~(4'b0001 << i)) begin
                        tests++;
                        if (seg !== want[i] || dp !== (i != 0)) begin
                            fails++;
                            $display("FAIL history_slot%0d: got seg=%h dp=%b, want seg=%h dp=%b", i, seg, dp, want[i], i != 0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [6:0] want [DIGITS];
        want = '{7'h78, 7'h30, 7'h24, 7'h79};
        for (int n = 0; n < 20; n++) begin
            drive_cycle(4'b1101);
            e = sb_q.pop_front(); tests++;
            if ({an, seg, dp, err, wrap_cnt} !== e) begin
                fails++;
                $display("FAIL sb_hold: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                         an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
            end
            if (n >= 4) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (an == ~(4'b0001 << i)) begin
                        tests++;
                        if (seg !== want[i]) begin
                            fails++;
                            $display("FAIL hold_slot%0d: got seg=%h, want seg=%h", i, seg, want[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [3:0] steps [3] = '{4'b1110, 4'b1111, 4'b0000};
        logic [6:0] want [DIGITS];
        want = '{7'h40, 7'h10, 7'h00, 7'h40};
        for (int it = 1; it <= 16; it++) begin
            for (int s = 0; s < 3; s++) begin
                drive_cycle(steps[s]);
                e = sb_q.pop_front(); tests++;
                if ({an, seg, dp, err, wrap_cnt} !== e) begin
                    fails++;
                    $display("FAIL sb_wrap: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                             an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
                end
            end
            tests++;
            if (wrap_cnt !== 4'(it % 16)) begin
                fails++;
                $display("FAIL wrap_count iter %0d: got %0d, want %0d", it, wrap_cnt, it % 16);
            end
        end
        for (int n = 0; n < 16; n++) begin
            drive_cycle(4'b0000);
            void'(sb_q.pop_front());
            for (int i = 0; i < DIGITS; i++) begin
                if (an == ~(4'b0001 << i)) begin
                    tests++;
                    if (seg !== want[i]) begin
                        fails++;
                        $display("FAIL wrap_slot%0d: got seg=%h, want seg=%h", i, seg, want[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        logic [6:0] want [DIGITS];
        want = '{7'h79, 7'h40, 7'h10, 7'h00};
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_before: got %b, want 0", err);
        end
        for (int n = 0; n < 21; n++) begin
            drive_cycle((n == 0) ? 4'b0110 : 4'b0001);
            e = sb_q.pop_front(); tests++;
            if ({an, seg, dp, err, wrap_cnt} !== e) begin
                fails++;
                $display("FAIL sb_illegal: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                         an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
            end
            tests++;
            if (err !== 1'b1) begin
                fails++;
                $display("FAIL err_sticky cycle %0d: got %b, want 1", n, err);
            end
            if (n >= 5) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (an == ~(4'b0001 << i)) begin
                        tests++;
                        if (seg !== want[i]) begin
                            fails++;
                            $display("FAIL illegal_slot%0d: got seg=%h, want seg=%h", i, seg, want[i]);
                        end
                    end
                end
            end
        end
        #1 reset = 1'b0;
        #1; tests++;
        if (err !== 1'b0 || wrap_cnt !== 4'd0) begin
            fails++;
            $display("FAIL err_clear: got err=%b wrap=%0d, want err=0 wrap=0", err, wrap_cnt);
        end
        release_reset();
    endtask

    task automatic test_scan_cadence();
        exp_t e;
        logic [3:0] want_an;
        for (int k = 1; k <= 32; k++) begin
            drive_cycle(4'b0000);
            e = sb_q.pop_front(); tests++;
            if ({an, seg, dp, err, wrap_cnt} !== e) begin
                fails++;
                $display("FAIL sb_scan: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                         an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
            end
            want_an = ~(4'b0001 << (((k - 1) / 4) % 4));
            tests++;
            if (an !== want_an) begin
                fails++;
                $display("FAIL scan_cadence edge %0d: got an=%b, want an=%b", k, an, want_an);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] c = 4'b0000;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) != 0) c = 4'($urandom_range(0, 15));
            drive_cycle(c);
            e = sb_q.pop_front(); tests++;
            if ({an, seg, dp, err, wrap_cnt} !== e) begin
                fails++;
                $display("FAIL sb_random cycle %0d: got an=%b seg=%h dp=%b err=%b wrap=%0d, want an=%b seg=%h dp=%b err=%b wrap=%0d",
                         n, an, seg, dp, err, wrap_cnt, e.an, e.seg, e.dp, e.err, e.wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_history();
        test_hold();
        test_wrap();
        test_illegal();
        test_scan_cadence();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
